alu_sequencer: RTL and testbench

//   Single-issue controller that executes one register-to-register ALU command.

---
 rtl/alu_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Single-issue ALU command sequencer: read two registers, drive the ALU,
// write the result back. One command in flight, valid/ready on the command side.
module alu_sequencer #(
  parameter int WORDSIZE = 64,
  parameter int SIZE     = 32,
  parameter int ADDR_W   = $clog2(SIZE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [4:0]          cmd_op,
  input  logic [ADDR_W-1:0]   cmd_rs1,
  input  logic [ADDR_W-1:0]   cmd_rs2,
  input  logic [ADDR_W-1:0]   cmd_rd,
  output logic [ADDR_W-1:0]   rf_ra1,
  output logic [ADDR_W-1:0]   rf_ra2,
  input  logic [WORDSIZE-1:0] rf_rd1,
  input  logic [WORDSIZE-1:0] rf_rd2,
  output logic [WORDSIZE-1:0] alu_a,
  output logic [WORDSIZE-1:0] alu_b,
  output logic [4:0]          alu_op,
  input  logic [WORDSIZE-1:0] alu_result,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_wa,
  output logic [WORDSIZE-1:0] rf_wd,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [4:0]          op_q, op_d;
  logic [ADDR_W-1:0]   rs1_q, rs1_d;
  logic [ADDR_W-1:0]   rs2_q, rs2_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic [WORDSIZE-1:0] opa_q, opa_d;
  logic [WORDSIZE-1:0] opb_q, opb_d;
  logic [WORDSIZE-1:0] res_q, res_d;
  logic                err_q, err_d;

  logic accept;
  logic illegal;

  assign accept  = (state_q == IDLE) && cmd_valid;
  assign illegal = (op_q > 5'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = READ;
      READ:  state_d = illegal ? WRITE : EXEC;
      EXEC:  state_d = WRITE;
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched command, operands and result; held between commands.
  always_comb begin
    op_d  = op_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    rd_d  = rd_q;
    opa_d = opa_q;
    opb_d = opb_q;
    res_d = res_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = cmd_op;
          rs1_d = cmd_rs1;
          rs2_d = cmd_rs2;
          rd_d  = cmd_rd;
          err_d = 1'b0;
        end
      end
      READ: begin
        opa_d = rf_rd1;
        opb_d = rf_rd2;
        err_d = illegal;
      end
      EXEC:  res_d = alu_result;
      WRITE: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
      opa_q <= '0;
      opb_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      op_q  <= op_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      rd_q  <= rd_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      res_q <= res_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    rf_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      READ: ;
      EXEC: ;
      WRITE: begin
        done  = 1'b1;
        err   = err_q;
        rf_we = ~err_q;
      end
      default: ;
    endcase
  end

  assign rf_ra1 = rs1_q;
  assign rf_ra2 = rs2_q;
  assign alu_a  = opa_q;
  assign alu_b  = opb_q;
  assign alu_op = op_q;
  assign rf_wa  = rd_q;
  assign rf_wd  = res_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a register file and ALU
// environment plus a shadow register-file reference model.
module tb_alu_sequencer;

  localparam int W = 64;
  localparam int A = 5;

  logic         clk = 0;
  logic         reset = 1;
  logic         cmd_valid = 0;
  logic         cmd_ready;
  logic [4:0]   cmd_op = 0;
  logic [A-1:0] cmd_rs1 = 0, cmd_rs2 = 0, cmd_rd = 0;
  logic [A-1:0] rf_ra1, rf_ra2, rf_wa;
  logic [W-1:0] rf_rd1, rf_rd2, alu_a, alu_b, alu_result, rf_wd;
  logic [4:0]   alu_op;
  logic         rf_we, busy, done, err;

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment: register file and ALU
  logic [W-1:0] rf [32];
  assign rf_rd1 = rf[rf_ra1];
  assign rf_rd2 = rf[rf_ra2];
  always @(posedge clk) if (rf_we) rf[rf_wa] <= rf_wd;

  always_comb begin
    case (alu_op)
      5'd0:    alu_result = alu_a;
      5'd1:    alu_result = alu_b;
      5'd2:    alu_result = alu_a + alu_b;
      5'd3:    alu_result = alu_a - alu_b;
      default: alu_result = '0;
    endcase
  end

  // Reference model
  logic [W-1:0] ref_rf [32];

  function automatic logic [W-1:0] ref_alu(input int op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      0: return a;
      1: return b;
      2: return a + b;
      3: return a - b;
      default: return '0;
    endcase
  endfunction

  typedef struct {
    int           rd;
    logic [W-1:0] val;
    bit           bad;
    int           due;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every retirement against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("err", err, e.bad);
          chk("rf_we", rf_we, !e.bad);
          chk("rf_wa", rf_wa, e.rd);
          if (!e.bad) chk("rf_wd", rf_wd, e.val);
        end
      end else if (rf_we || err) begin
        chk("pulse_without_done", {rf_we, err}, 0);
      end
    end
  end

  task automatic issue(input int op, input int rs1, input int rs2,
                       input int rd, input bit track,
                       output int acc, output int waits);
    exp_t e;
    @(negedge clk);
    cmd_valid = 1;
    cmd_op = 5'(op);
    cmd_rs1 = A'(rs1);
    cmd_rs2 = A'(rs2);
    cmd_rd = A'(rd);
    waits = 0;
    while (!cmd_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 0;
      acc = -1;
      return;
    end
    acc = cyc;
    if (track) begin
      e.rd = rd;
      e.bad = (op > 3);
      e.val = ref_alu(op, ref_rf[rs1], ref_rf[rs2]);
      e.due = acc + (e.bad ? 2 : 3);
      if (!e.bad) ref_rf[rd] = e.val;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sbq.size(), 0);
  endtask

  task automatic setreg(input int i, input logic [W-1:0] v);
    rf[i] = v;
    ref_rf[i] = v;
  endtask

  initial begin
    int acc, acc2, w;
    for (int i = 0; i < 32; i++) setreg(i, {$urandom, $urandom});

    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_outs", {busy, done, err, rf_we}, 0);
    chk("rst_data", alu_a | alu_b | rf_wd, 0);
    repeat (2) @(negedge clk);
    reset = 0;

    setreg(1, 64'h3333);
    setreg(2, 64'h1111);
    issue(2, 1, 2, 3, 1, acc, w);
    cmd_valid = 0;
    drain();
    chk("R3_add", rf[3], 64'h4444);
    for (int op = 0; op < 4; op++) begin
      issue(op, 1, 2, 5 + op, 1, acc, w);
      cmd_valid = 0;
    end
    drain();

    setreg(1, 64'h0);
    setreg(2, 64'h1);
    issue(3, 1, 2, 9, 1, acc, w);
    cmd_valid = 0;
    drain();
    chk("R9_wrap", rf[9], 64'hFFFF_FFFF_FFFF_FFFF);

    issue(5, 1, 2, 10, 1, acc, w);
    cmd_valid = 0;
    while (cyc < acc + 3) @(negedge clk);
    chk("illegal_idle", cmd_ready, 1);
    drain();

    setreg(1, 64'h3333);
    setreg(2, 64'h1111);
    issue(2, 1, 2, 3, 1, acc, w);
    issue(3, 3, 2, 4, 1, acc2, w);
    cmd_valid = 0;
    chk("b2b_waits", w, 3);
    chk("b2b_gap", acc2 - acc, 4);
    drain();
    chk("R4_raw", rf[4], 64'h3333);

    for (int k = 0; k < 40; k++) begin
      int op;
      op = ($urandom_range(0, 4) == 0) ? $urandom_range(4, 31)
                                       : $urandom_range(0, 3);
      issue(op, $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 31), 1, acc, w);
      if ($urandom_range(0, 1) == 0) cmd_valid = 0;
    end
    cmd_valid = 0;
    drain();

    issue(2, 6, 7, 11, 0, acc, w);
    cmd_valid = 0;
    repeat (2) @(negedge clk);
    chk("exec_busy", busy, 1);
    reset = 1;
    #1;
    chk("rst_exec_outs", {busy, done, err, rf_we}, 0);
    chk("rst_exec_data", alu_a | alu_b | rf_wd | W'(alu_op), 0);
    chk("rst_exec_addr", {rf_ra1, rf_ra2, rf_wa}, 0);
    @(negedge clk);
    reset = 0;
    #1;
    chk("rel_ready", cmd_ready, 1);
    repeat (6) @(negedge clk);

    for (int i = 0; i < 32; i++) chk($sformatf("rf%0d", i), rf[i], ref_rf[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
